// File: rtl/yin_tau_picker.sv
// YIN absolute-threshold tau picker: consumes d'(tau) beats for tau 1..MAX_TAU-1, emits one result per frame.
// Optional macro YIN_GLOBAL_MIN_FALLBACK_EN: unvoiced frames report the global minimum instead of tau=0/all-ones.
module yin_tau_picker #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MAX_TAU    = 40,
    parameter int unsigned TAU_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] threshold,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_value,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAU_BITS-1:0]   out_tau,
    output logic [DATA_WIDTH-1:0] out_value,
    output logic                  out_voiced,
    output logic                  out_short
);

    localparam logic [TAU_BITS-1:0] LAST_TAU  = TAU_BITS'(MAX_TAU - 1);
    localparam logic [TAU_BITS-1:0] FIRST_TAU = TAU_BITS'(1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        DESCEND = 2'd1,
        DRAIN   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t                state;
    logic [TAU_BITS-1:0]   tau_cnt;
    logic [DATA_WIDTH-1:0] thr_q;
    logic [DATA_WIDTH-1:0] best_val;
    logic [TAU_BITS-1:0]   best_tau;

    logic                  accept;
    logic                  first_beat;
    logic                  closing;
    logic                  below_thr;
    logic [DATA_WIDTH-1:0] thr_eff;
    state_t                eval_state;
    logic [DATA_WIDTH-1:0] eval_val;
    logic [TAU_BITS-1:0]   eval_tau;
    logic [DATA_WIDTH-1:0] unvoiced_val;
    logic [TAU_BITS-1:0]   unvoiced_tau;

    // Evaluate the current beat against the search state; the first beat compares against the live threshold.
    always_comb begin
        accept     = in_valid && in_ready;
        first_beat = (tau_cnt == FIRST_TAU);
        closing    = in_last || (tau_cnt == LAST_TAU);
        thr_eff    = first_beat ? threshold : thr_q;
        below_thr  = (in_value < thr_eff);
        eval_state = state;
        eval_val   = best_val;
        eval_tau   = best_tau;
        case (state)
            SEARCH: begin
                if (below_thr) begin
                    eval_state = DESCEND;
                    eval_val   = in_value;
                    eval_tau   = tau_cnt;
                end
            end
            DESCEND: begin
                if (in_value < best_val) begin
                    eval_val = in_value;
                    eval_tau = tau_cnt;
                end else begin
                    eval_state = DRAIN;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef YIN_GLOBAL_MIN_FALLBACK_EN
    logic [DATA_WIDTH-1:0] gmin_val;
    logic [TAU_BITS-1:0]   gmin_tau;
    logic [DATA_WIDTH-1:0] gmin_next_val;
    logic [TAU_BITS-1:0]   gmin_next_tau;

    // Running global minimum including the current beat; strict < keeps the earliest tau on ties.
    always_comb begin
        gmin_next_val = gmin_val;
        gmin_next_tau = gmin_tau;
        if (first_beat || (in_value < gmin_val)) begin
            gmin_next_val = in_value;
            gmin_next_tau = tau_cnt;
        end
        unvoiced_val = gmin_next_val;
        unvoiced_tau = gmin_next_tau;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gmin_val <= '0;
            gmin_tau <= '0;
        end else if (accept) begin
            gmin_val <= gmin_next_val;
            gmin_tau <= gmin_next_tau;
        end
    end
`else
    always_comb begin
        unvoiced_val = '1;
        unvoiced_tau = '0;
    end
`endif

    // Frame FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            tau_cnt    <= FIRST_TAU;
            thr_q      <= '0;
            best_val   <= '0;
            best_tau   <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_tau    <= '0;
            out_value  <= '0;
            out_voiced <= 1'b0;
            out_short  <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (out_ready) begin
                        state     <= SEARCH;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (first_beat) begin
                            thr_q <= threshold;
                        end
                        best_val <= eval_val;
                        best_tau <= eval_tau;
                        if (closing) begin
                            state     <= HOLD;
                            tau_cnt   <= FIRST_TAU;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            out_short <= in_last && (tau_cnt < LAST_TAU);
                            if (eval_state != SEARCH) begin
                                out_voiced <= 1'b1;
                                out_tau    <= eval_tau;
                                out_value  <= eval_val;
                            end else begin
                                out_voiced <= 1'b0;
                                out_tau    <= unvoiced_tau;
                                out_value  <= unvoiced_val;
                            end
                        end else begin
                            state   <= eval_state;
                            tau_cnt <= tau_cnt + TAU_BITS'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yin_tau_picker.sv
// Randomized scoreboard bench for yin_tau_picker; compile with the same YIN_GLOBAL_MIN_FALLBACK_EN setting as the RTL.
module tb_yin_tau_picker;

    localparam int NT = 39;

    typedef struct packed {
        logic [5:0]  tau;
        logic [63:0] val;
        logic        voiced;
        logic        short_f;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] threshold;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_tau;
    logic [63:0] out_value;
    logic        out_voiced;
    logic        out_short;

    int   checks   = 0;
    int   failures = 0;
    bit   hold_low = 1'b0;
    exp_t sb[$];
    logic [63:0] frame_v [1:NT];

    yin_tau_picker dut (
        .clk(clk), .reset(reset), .threshold(threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_tau(out_tau),
        .out_value(out_value), .out_voiced(out_voiced), .out_short(out_short)
    );

    always #5 clk = ~clk;

    // Reference: first tau below threshold, then walk down while strictly decreasing.
    function automatic exp_t model(input logic [63:0] thr, input int len);
        exp_t e;
        int   first = 0;
        int   t;
        for (int i = 1; i <= len; i++) begin
            if (first == 0 && frame_v[i] < thr) first = i;
        end
        if (first != 0) begin
            t = first;
            while (t < len && frame_v[t+1] < frame_v[t]) t++;
            e.tau    = 6'(t);
            e.val    = frame_v[t];
            e.voiced = 1'b1;
        end else begin
`ifdef YIN_GLOBAL_MIN_FALLBACK_EN
            t = 1;
            for (int i = 2; i <= len; i++) if (frame_v[i] < frame_v[t]) t = i;
            e.tau = 6'(t);
            e.val = frame_v[t];
`else
            e.tau = 6'd0;
            e.val = '1;
`endif
            e.voiced = 1'b0;
        end
        e.short_f = (len < NT);
        return e;
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Result consumer: randomly throttled unless the bench forces backpressure.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop and compare on every accepted result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result actual tau=%0d val=%0h voiced=%0b", out_tau, out_value, out_voiced);
            end else begin
                e = sb.pop_front();
                if (out_tau !== e.tau || out_value !== e.val || out_voiced !== e.voiced || out_short !== e.short_f) begin
                    failures++;
                    $display("FAIL result actual tau=%0d val=%0h voiced=%0b short=%0b required tau=%0d val=%0h voiced=%0b short=%0b",
                             out_tau, out_value, out_voiced, out_short, e.tau, e.val, e.voiced, e.short_f);
                end
            end
        end
    end

    task automatic wait_accept();
        int n   = 0;
        bit got = 1'b0;
        while (!got) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                $display("FAIL accept_timeout actual=stalled required=accepted");
                $fatal(1);
            end
        end
    endtask

    // Drive one frame; abort=1 sends beats only (no result expected, no in_last).
    task automatic drive_frame(input logic [63:0] thr, input int len, input bit last_on_full, input bit abort);
        if (!abort) sb.push_back(model(thr, len));
        threshold = thr;
        for (int t = 1; t <= len; t++) begin
            while ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_value = frame_v[t];
            in_last  = !abort && (t == len) && (len < NT || last_on_full);
            wait_accept();
            if (t == 1) threshold = {$urandom, $urandom};
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!abort) begin
            @(negedge clk);
            check("valid_after_close", 64'(out_valid), 64'd1);
        end
    endtask

    task automatic fill_bg();
        for (int t = 1; t <= NT; t++) frame_v[t] = 64'd500;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'd0);
        check({name, "_ready"}, 64'(in_ready), 64'd1);
        check({name, "_tau"}, 64'(out_tau), 64'd0);
        check({name, "_value"}, out_value, 64'd0);
        check({name, "_flags"}, {62'd0, out_voiced, out_short}, 64'd0);
    endtask

    initial begin
        logic [5:0]  h_tau;
        logic [63:0] h_val;
        logic        h_voi;
        logic        h_sht;

        reset = 1'b1; threshold = '0; in_valid = 1'b0; in_value = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("reset");

        // Threshold hit followed by descent.
        fill_bg(); frame_v[10] = 90; frame_v[11] = 70; frame_v[12] = 80;
        drive_frame(64'd100, NT, 1'b0, 1'b0);
        // No crossing.
        fill_bg(); frame_v[20] = 200;
        drive_frame(64'd100, NT, 1'b1, 1'b0);
        // Descent running into the last tau.
        fill_bg(); frame_v[37] = 90; frame_v[38] = 80; frame_v[39] = 60;
        drive_frame(64'd100, NT, 1'b0, 1'b0);
        // Tie ends descent.
        fill_bg(); frame_v[5] = 50; frame_v[6] = 50;
        drive_frame(64'd100, NT, 1'b0, 1'b0);
        drain("drain_directed");

        // Backpressure: result held for 5 cycles while upstream offers a beat.
        hold_low = 1'b1;
        fill_bg(); frame_v[10] = 90; frame_v[11] = 70; frame_v[12] = 80;
        drive_frame(64'd100, NT, 1'b0, 1'b0);
        h_tau = out_tau; h_val = out_value; h_voi = out_voiced; h_sht = out_short;
        in_valid = 1'b1; in_value = 64'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_stable", {out_tau, out_value[31:0], out_voiced, out_short, 24'd0},
                  {h_tau, h_val[31:0], h_voi, h_sht, 24'd0});
        end
        in_valid = 1'b0;
        hold_low = 1'b0;
        fill_bg(); frame_v[3] = 20; frame_v[4] = 10;
        drive_frame(64'd100, NT, 1'b0, 1'b0);

        // Short frame.
        fill_bg(); frame_v[8] = 40;
        drive_frame(64'd100, 20, 1'b0, 1'b0);
        drain("drain_short");

        // Mid-frame reset discards the partial frame.
        fill_bg(); frame_v[5] = 10;
        drive_frame(64'd100, 15, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("midreset");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("midreset_no_valid", 64'(out_valid), 64'd0);
        end
        fill_bg(); frame_v[10] = 90; frame_v[11] = 70; frame_v[12] = 80;
        drive_frame(64'd100, NT, 1'b0, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            int          len;
            int          mode;
            logic [63:0] thr;
            mode = $urandom_range(0, 3);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NT - 1) : NT;
            thr  = 64'($urandom_range(0, 300));
            for (int t = 1; t <= NT; t++) begin
                case (mode)
                    0:       frame_v[t] = 64'($urandom_range(0, 1000));
                    1:       frame_v[t] = 64'($urandom_range(95, 105));
                    2:       frame_v[t] = {$urandom, $urandom};
                    default: frame_v[t] = 64'($urandom_range(0, 50));
                endcase
            end
            if (mode == 2) thr = {$urandom, $urandom};
            if (mode == 3) thr = 64'd0;
            drive_frame(thr, len, 1'($urandom_range(0, 1)), 1'b0);
        end
        drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
